// File: rtl/ntt_addr_gen.sv
// ---------------------------------------------------------------------------
// ntt_addr_gen
//   Operand sequencer for a two-lane Kyber butterfly. It walks the NTT
//   (forward) or INTT (inverse) layers over a packed coefficient RAM. Each
//   24-bit word holds two 12-bit coefficients. For every butterfly it issues
//   one read pair plus a twiddle ROM index. The pair's addresses are delayed
//   by the RAM + butterfly latency and then issued as the write-back. Between
//   layers the pipeline drains, so no read of layer l+1 overtakes a pending
//   write of layer l.
//
// Parameters
//   WORDS    coefficient RAM depth in words (power of two)
//   AW       word address width, log2(WORDS)
//   RAM_LAT  cycles from rd_en to RAM data at butterfly in0/in1
//   BF_LAT   butterfly latency, in0/in1 to out0/out1
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active-high (aborts a run)
//   start     in   1-cycle run request, sampled only in IDLE
//   inv       in   0 = forward NTT, 1 = inverse NTT; latched at start
//   busy      out  high while issuing/draining
//   done      out  1-cycle pulse after the final write of the final layer
//   rd_en     out  read strobe for both RAM ports
//   rd_addr0  out  word address of upper-of-pair (butterfly in0)
//   rd_addr1  out  word address of lower-of-pair (butterfly in1)
//   tw_addr   out  twiddle ROM index, aligned with rd_en
//   bf_inv    out  latched inv, constant during a run
//   wr_en     out  write strobe, rd_en delayed by RAM_LAT+BF_LAT
//   wr_addr0  out  rd_addr0 delayed by RAM_LAT+BF_LAT
//   wr_addr1  out  rd_addr1 delayed by RAM_LAT+BF_LAT
// ---------------------------------------------------------------------------
module ntt_addr_gen #(
  parameter int WORDS   = 128,
  parameter int AW      = 7,
  parameter int RAM_LAT = 1,
  parameter int BF_LAT  = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          inv,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr0,
  output logic [AW-1:0] rd_addr1,
  output logic [AW-1:0] tw_addr,
  output logic          bf_inv,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr0,
  output logic [AW-1:0] wr_addr1
);

  localparam int PIPE_LAT = RAM_LAT + BF_LAT;
  localparam int PW       = $clog2(WORDS) - 1;  // pair counter width (WORDS/2 pairs)
  localparam int LW       = $clog2(AW);         // layer counter width
  localparam int SW       = LW + 1;             // shift amounts reach AW

  localparam logic [PW-1:0] LAST_PAIR  = {PW{1'b1}};
  localparam logic [PW-1:0] PAIR_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] LAST_LAYER = LW'(AW - 1);
  localparam logic [LW-1:0] LAYER_ONE  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] TOP_SHIFT  = SW'(AW - 1);
  localparam logic [SW-1:0] SHIFT_ONE  = {{(SW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q,    state_d;
  logic [PW-1:0] pair_q,     pair_d;
  logic [LW-1:0] layer_q,    layer_d;
  logic          bf_inv_q,   bf_inv_d;
  logic          busy_q,     busy_d;
  logic          done_q,     done_d;
  logic          rd_en_q,    rd_en_d;
  logic [AW-1:0] rd_addr0_q, rd_addr0_d;
  logic [AW-1:0] rd_addr1_q, rd_addr1_d;
  logic [AW-1:0] tw_addr_q,  tw_addr_d;

  // Write-back delay line: stage PIPE_LAT-1 drives the write port.
  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [AW-1:0]       pa0_q [PIPE_LAT];
  logic [AW-1:0]       pa0_d [PIPE_LAT];
  logic [AW-1:0]       pa1_q [PIPE_LAT];
  logic [AW-1:0]       pa1_d [PIPE_LAT];

  // Address arithmetic for the current (layer, pair).
  logic [SW-1:0] sh_s;    // log2(half)
  logic [SW-1:0] gsh_s;   // log2(number of groups)
  logic [AW-1:0] pair_s;
  logic [AW-1:0] half_s;
  logic [AW-1:0] grp_s;
  logic [AW-1:0] g_s;
  logic [AW-1:0] j_s;
  logic [AW-1:0] a0_s;
  logic [AW-1:0] tw_s;

  logic later_pend_s;
  logic any_pend_s;

  // Butterfly pair and twiddle index from the pair and layer counters
  always_comb begin
    // Forward halves the span every layer (64..1); inverse doubles it (1..64).
    if (bf_inv_q) begin
      sh_s = {1'b0, layer_q};
    end else begin
      sh_s = TOP_SHIFT - {1'b0, layer_q};
    end
    gsh_s  = TOP_SHIFT - sh_s;
    pair_s = {{(AW-PW){1'b0}}, pair_q};
    half_s = ADDR_ONE << sh_s;
    grp_s  = ADDR_ONE << gsh_s;
    g_s    = pair_s >> sh_s;
    j_s    = pair_s & (half_s - ADDR_ONE);
    a0_s   = (g_s << (sh_s + SHIFT_ONE)) | j_s;
    // 2G wraps to 0 in AW bits when G = WORDS/2; the modular result is still
    // the correct 2G-1-g because the true value always fits in AW bits.
    if (bf_inv_q) begin
      tw_s = {grp_s[AW-2:0], 1'b0} - ADDR_ONE - g_s;
    end else begin
      tw_s = grp_s + g_s;
    end
  end

  // Pending-write view of the delay line used to end DRAIN
  always_comb begin
    // A read issued from the next ISSUE cycle registers one edge later. It
    // reaches RAM one edge after that. Entries in the last two stages have
    // then been written. Between layers, only the earlier stages must be empty.
    later_pend_s = rd_en_q | (|vld_q[PIPE_LAT-3:0]);
    // Before DONE, every write must be retired, so done never meets wr_en.
    any_pend_s   = rd_en_q | (|vld_q);
  end

  // FSM next-state and registered-output next values
  always_comb begin
    state_d    = state_q;
    pair_d     = pair_q;
    layer_d    = layer_q;
    bf_inv_d   = bf_inv_q;
    rd_en_d    = 1'b0;
    rd_addr0_d = rd_addr0_q;
    rd_addr1_d = rd_addr1_q;
    tw_addr_d  = tw_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ISSUE;
          bf_inv_d = inv;
          pair_d   = {PW{1'b0}};
          layer_d  = {LW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        rd_en_d    = 1'b1;
        rd_addr0_d = a0_s;
        rd_addr1_d = a0_s | half_s;  // j < half, so OR equals ADD
        tw_addr_d  = tw_s;
        pair_d     = pair_q + PAIR_ONE;  // wraps to 0 after the last pair
        if (pair_q == LAST_PAIR) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_DRAIN: begin
        if (layer_q == LAST_LAYER) begin
          if (!any_pend_s) begin
            state_d = S_DONE;
            layer_d = {LW{1'b0}};
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          if (!later_pend_s) begin
            state_d = S_ISSUE;
            layer_d = layer_q + LAYER_ONE;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // Delay-line next values; it shifts every cycle, including DRAIN
  always_comb begin
    vld_d    = {vld_q[PIPE_LAT-2:0], rd_en_q};
    pa0_d[0] = rd_addr0_q;
    pa1_d[0] = rd_addr1_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      pa0_d[i] = pa0_q[i-1];
      pa1_d[i] = pa1_q[i-1];
    end
  end

  // State, counters, registered outputs and delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pair_q     <= {PW{1'b0}};
      layer_q    <= {LW{1'b0}};
      bf_inv_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr0_q <= {AW{1'b0}};
      rd_addr1_q <= {AW{1'b0}};
      tw_addr_q  <= {AW{1'b0}};
      vld_q      <= {PIPE_LAT{1'b0}};
      for (int i = 0; i < PIPE_LAT; i++) begin
        pa0_q[i] <= {AW{1'b0}};
        pa1_q[i] <= {AW{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      pair_q     <= pair_d;
      layer_q    <= layer_d;
      bf_inv_q   <= bf_inv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_addr0_q <= rd_addr0_d;
      rd_addr1_q <= rd_addr1_d;
      tw_addr_q  <= tw_addr_d;
      vld_q      <= vld_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pa0_q[i] <= pa0_d[i];
        pa1_q[i] <= pa1_d[i];
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign rd_addr0 = rd_addr0_q;
  assign rd_addr1 = rd_addr1_q;
  assign tw_addr  = tw_addr_q;
  assign bf_inv   = bf_inv_q;
  assign wr_en    = vld_q[PIPE_LAT-1];
  assign wr_addr0 = pa0_q[PIPE_LAT-1];
  assign wr_addr1 = pa1_q[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_ntt_addr_gen
//   Directed bench for ntt_addr_gen at default parameters. Expected read
//   pairs come from a textbook group/offset enumeration of each layer. The
//   rd_en timing comes from the fixed layer period (64 issue + 10 drain
//   cycles). Writes are checked against the bench's own record of reads ten
//   cycles earlier. A pending-write table flags any read of an address whose
//   write-back has not yet appeared.
// ---------------------------------------------------------------------------
module tb_ntt_addr_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       inv;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [6:0] rd_addr0;
  logic [6:0] rd_addr1;
  logic [6:0] tw_addr;
  logic       bf_inv;
  logic       wr_en;
  logic [6:0] wr_addr0;
  logic [6:0] wr_addr1;

  int    n_cmp;
  int    n_mis;
  string run_nm;

  ntt_addr_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .inv      (inv),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .tw_addr  (tw_addr),
    .bf_inv   (bf_inv),
    .wr_en    (wr_en),
    .wr_addr0 (wr_addr0),
    .wr_addr1 (wr_addr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s/%s: got %0d, want %0d", run_nm, tag, obs, exp);
    end
  endtask

  task automatic check_all_zero();
    check("z.busy", busy, 0);
    check("z.done", done, 0);
    check("z.rd_en", rd_en, 0);
    check("z.rd_addr0", rd_addr0, 0);
    check("z.rd_addr1", rd_addr1, 0);
    check("z.tw_addr", tw_addr, 0);
    check("z.bf_inv", bf_inv, 0);
    check("z.wr_en", wr_en, 0);
    check("z.wr_addr0", wr_addr0, 0);
    check("z.wr_addr1", wr_addr1, 0);
  endtask

  // One run. stray_cyc: cycle with a spurious start pulse (-1 = none).
  // abort_cyc: cycle after which rst is pulsed and the run abandoned (-1 = none).
  task automatic run_seq(input logic inv_i, input int stray_cyc, input int abort_cyc);
    int q0[$];
    int q1[$];
    int qt[$];
    int h_en[0:599];
    int h0[0:599];
    int h1[0:599];
    int pend[0:127];
    int n_rd;
    int n_wr;
    int half;
    int grp;
    int base;
    int lyr;
    int off;
    int e_rd;
    n_rd = 0;
    n_wr = 0;
    for (int l = 0; l < 7; l++) begin
      half = inv_i ? (1 << l) : (128 >> (l + 1));
      grp  = 128 / (2 * half);
      for (int g = 0; g < grp; g++) begin
        for (int j = 0; j < half; j++) begin
          base = g * 2 * half + j;
          q0.push_back(base);
          q1.push_back(base + half);
          qt.push_back(inv_i ? (2 * grp - 1 - g) : (grp + g));
        end
      end
    end
    for (int a = 0; a < 128; a++) pend[a] = 0;

    @(negedge clk);
    start = 1'b1;
    inv   = inv_i;
    for (int cyc = 0; cyc <= 525; cyc++) begin
      @(negedge clk);
      // Values registered by the cyc-th edge after the start edge.
      lyr  = (cyc - 1) / 74;
      off  = (cyc - 1) % 74;
      e_rd = (cyc >= 1 && lyr < 7 && off < 64) ? 1 : 0;
      check("rd_en", rd_en, e_rd);
      h_en[cyc] = rd_en;
      h0[cyc]   = rd_addr0;
      h1[cyc]   = rd_addr1;
      if (rd_en) begin
        n_rd++;
        if (q0.size() == 0) begin
          check("rd_extra", 1, 0);
        end else begin
          check("rd_addr0", rd_addr0, q0.pop_front());
          check("rd_addr1", rd_addr1, q1.pop_front());
          check("tw_addr", tw_addr, qt.pop_front());
        end
        check("raw_hazard", pend[rd_addr0] + pend[rd_addr1], 0);
      end
      if (cyc >= 10) begin
        check("wr_en", wr_en, h_en[cyc-10]);
        if (wr_en) begin
          check("wr_addr0", wr_addr0, h0[cyc-10]);
          check("wr_addr1", wr_addr1, h1[cyc-10]);
        end
      end else begin
        check("wr_en_early", wr_en, 0);
      end
      if (wr_en) begin
        n_wr++;
        pend[wr_addr0]--;
        pend[wr_addr1]--;
      end
      if (rd_en) begin
        pend[rd_addr0]++;
        pend[rd_addr1]++;
      end
      check("done", done, (cyc == 520) ? 1 : 0);
      check("busy", busy, (cyc < 520) ? 1 : 0);
      if (cyc < 520) check("bf_inv", bf_inv, inv_i);
      // Hand-computed spot points.
      if (!inv_i && cyc == 1) begin
        check("f_p0_rd0", rd_addr0, 0);
        check("f_p0_rd1", rd_addr1, 64);
        check("f_p0_tw", tw_addr, 1);
      end
      if (!inv_i && cyc == 64) begin
        check("f_p63_rd0", rd_addr0, 63);
        check("f_p63_rd1", rd_addr1, 127);
      end
      if (!inv_i && cyc == 450) begin
        check("f_l6p5_rd0", rd_addr0, 10);
        check("f_l6p5_rd1", rd_addr1, 11);
        check("f_l6p5_tw", tw_addr, 69);
      end
      if (inv_i && cyc == 6) begin
        check("i_l0p5_rd0", rd_addr0, 10);
        check("i_l0p5_rd1", rd_addr1, 11);
        check("i_l0p5_tw", tw_addr, 122);
      end
      if (cyc == abort_cyc) begin
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_all_zero();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          check("ab.wr_en", wr_en, 0);
          check("ab.rd_en", rd_en, 0);
          check("ab.busy", busy, 0);
        end
        return;
      end
      start = (cyc == stray_cyc) ? 1'b1 : 1'b0;
      inv   = ~inv_i;  // bf_inv must hold the value latched at start
    end
    start = 1'b0;
    check("n_rd", n_rd, 448);
    check("n_wr", n_wr, 448);
  endtask

  initial begin
    n_cmp  = 0;
    n_mis  = 0;
    run_nm = "reset";
    rst    = 1'b1;
    start  = 1'b0;
    inv    = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero();

    run_nm = "fwd";
    run_seq(1'b0, -1, -1);
    run_nm = "inv";
    run_seq(1'b1, -1, -1);
    run_nm = "stray_start";
    run_seq(1'b0, 100, -1);
    run_nm = "abort";
    run_seq(1'b0, -1, 300);
    run_nm = "after_abort";
    run_seq(1'b0, -1, -1);

    // start in the same cycle as rst: reset wins, nothing starts.
    run_nm = "rst_start";
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("busy", busy, 0);
      check("rd_en", rd_en, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
